// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default bundle widths for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_e;
  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 122;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one pipeline entry (valid, ctrl, data) with load, clear and flush
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 122,
  parameter int FLUSH_DATA = 0
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  // ctrl is zeroed whenever the entry goes invalid so an empty slot always reads as a NOP
  always_ff @(posedge clk_i)
    if (!start_i) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (FLUSH_DATA != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with optional 2-entry skid buffer and flush
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);
  state_e state_q, state_d;
  logic rdy_q, acc, emit, from_skid, main_ld, main_clr;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  assign in_ready_o = (SKID != 0) ? rdy_q : start_i & (!out_valid_o | out_ready_i);
  assign acc = in_valid_i & in_ready_o;
  assign emit = out_valid_o & out_ready_i;
  assign from_skid = state_q == ST_FULL;
  assign main_ld = (state_q == ST_EMPTY & acc) | (state_q == ST_ONE & acc & emit) | (from_skid & emit);
  assign main_clr = state_q == ST_ONE & emit & !acc;
  assign count_o = state_q;
  always_comb begin
    state_d = state_q;
    if (SKID == 0)
      state_d = acc ? ST_ONE : emit ? ST_EMPTY : state_q;
    else
      state_d = state_q == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY) :
                state_q == ST_ONE   ? (acc & !emit ? ST_FULL : emit & !acc ? ST_EMPTY : ST_ONE) :
                                      (emit ? ST_ONE : ST_FULL);
  end
  // ready is registered from the next state so it never depends on out_ready_i combinationally
  always_ff @(posedge clk_i)
    if (!start_i) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= flush_i ? ST_EMPTY : state_d;
      rdy_q   <= flush_i | (state_d != ST_FULL);
    end
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_DATA(FLUSH_DATA)) u_main (
    .clk_i   (clk_i),
    .start_i (start_i),
    .flush   (flush_i),
    .load    (main_ld),
    .clear   (main_clr),
    .ld_ctrl (from_skid ? skid_ctrl : in_ctrl_i),
    .ld_data (from_skid ? skid_data : in_data_i),
    .valid   (out_valid_o),
    .ctrl    (out_ctrl_o),
    .data    (out_data_o)
  );
  generate
    if (SKID != 0) begin : g_skid
      logic unused_skid_valid;
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_DATA(FLUSH_DATA)) u_skid (
        .clk_i   (clk_i),
        .start_i (start_i),
        .flush   (flush_i),
        .load    (state_q == ST_ONE & acc & !emit),
        .clear   (from_skid & emit),
        .ld_ctrl (in_ctrl_i),
        .ld_data (in_data_i),
        .valid   (unused_skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate
  a_no_acc_full: assert property (@(posedge clk_i) disable iff (!start_i)
    !(acc && state_q == ST_FULL));
  a_stall_stable: assert property (@(posedge clk_i)
    (start_i && !flush_i && out_valid_o && !out_ready_i) |=> (!start_i || $stable({out_valid_o, out_ctrl_o, out_data_o})));
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed table, corner sequences and random FIFO scoreboard for both SKID modes
module tb_pipe_stage_skid;
  localparam int CW = 8;
  localparam int DW = 16;
  logic clk = 1'b0, start_i = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [CW-1:0] in_ctrl_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic [1:0] rdy, ov;
  logic [1:0][CW-1:0] oc;
  logic [1:0][DW-1:0] od;
  logic [1:0][1:0] cnt;
  int n_chk = 0, n_fail = 0;
  // index 0: SKID=1 FLUSH_DATA=1, index 1: SKID=0 FLUSH_DATA=0
  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .FLUSH_DATA(1)) u_skid (
    .clk_i(clk), .start_i(start_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy[0]),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i), .out_valid_o(ov[0]), .out_ready_i(out_ready_i),
    .out_ctrl_o(oc[0]), .out_data_o(od[0]), .count_o(cnt[0]));
  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .FLUSH_DATA(0)) u_pass (
    .clk_i(clk), .start_i(start_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(rdy[1]),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i), .out_valid_o(ov[1]), .out_ready_i(out_ready_i),
    .out_ctrl_o(oc[1]), .out_data_o(od[1]), .count_o(cnt[1]));
  always #5 clk = ~clk;
  typedef struct {
    logic v, r, f;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic eov;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [1:0] ecnt;
    logic erdy;
  } vec_t;
  vec_t tbl[15];
  logic [CW-1:0] mc[2][2];
  logic [DW-1:0] md[2][2];
  int sz[2];
  logic acc_m[2], emit_m[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic r, input logic f, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid_i = v;
    out_ready_i = r;
    flush_i = f;
    in_ctrl_i = c;
    in_data_i = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 16'hA001, 1'b1, 8'h01, 16'hA001, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h02, 16'hA002, 1'b1, 8'h01, 16'hA001, 2'd2, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h03, 16'hA003, 1'b1, 8'h01, 16'hA001, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h03, 16'hA003, 1'b1, 8'h02, 16'hA002, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h03, 16'hA003, 1'b1, 8'h02, 16'hA002, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h03, 16'hA003, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h04, 16'hA004, 1'b1, 8'h04, 16'hA004, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h05, 16'hA005, 1'b1, 8'h04, 16'hA004, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h06, 16'hA006, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h07, 16'hA007, 1'b1, 8'h07, 16'hA007, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h08, 16'hA008, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h09, 16'hA009, 1'b1, 8'h09, 16'hA009, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b1};
    // reset with an item offered
    drive(1'b1, 1'b0, 1'b0, 8'h55, 16'h5555);
    tick;
    tick;
    for (int k = 0; k < 2; k++) begin
      chk("rst_count", 32'(cnt[k]), 32'd0);
      chk("rst_valid", 32'(ov[k]), 32'd0);
      chk("rst_ctrl", 32'(oc[k]), 32'd0);
      chk("rst_ready", 32'(rdy[k]), 32'd0);
    end
    start_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick;
    for (int k = 0; k < 2; k++) chk("rel_ready", 32'(rdy[k]), 32'd1);
    // streaming: back-to-back with downstream always ready
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(8'h10 + i), 16'(16'hB000 + i));
      tick;
      for (int k = 0; k < 2; k++) begin
        chk("str_valid", 32'(ov[k]), 32'd1);
        chk("str_ctrl", 32'(oc[k]), 32'(8'h10 + i));
        chk("str_data", 32'(od[k]), 32'(16'hB000 + i));
        chk("str_count", 32'(cnt[k]), 32'd1);
        chk("str_ready", 32'(rdy[k]), 32'd1);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
    tick;
    for (int k = 0; k < 2; k++) begin
      chk("drain_valid", 32'(ov[k]), 32'd0);
      chk("drain_ctrl", 32'(oc[k]), 32'd0);
    end
    // skid stall, accept+emit and flush table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].c, tbl[i].d);
      tick;
      chk($sformatf("tbl%0d_valid", i), 32'(ov[0]), 32'(tbl[i].eov));
      chk($sformatf("tbl%0d_ctrl", i), 32'(oc[0]), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_count", i), 32'(cnt[0]), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_ready", i), 32'(rdy[0]), 32'(tbl[i].erdy));
      if (tbl[i].eov || tbl[i].f) chk($sformatf("tbl%0d_data", i), 32'(od[0]), 32'(tbl[i].ed));
    end
    // pass-through ready: stall then simultaneous accept+emit, then flush keeps payload
    drive(1'b1, 1'b0, 1'b0, 8'h21, 16'hC021);
    tick;
    chk("pass_stall_valid", 32'(ov[1]), 32'd1);
    chk("pass_stall_ready", 32'(rdy[1]), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h22, 16'hC022);
    #1;
    chk("pass_thru_ready", 32'(rdy[1]), 32'd1);
    tick;
    for (int k = 0; k < 2; k++) begin
      chk("ae_ctrl", 32'(oc[k]), 32'h22);
      chk("ae_data", 32'(od[k]), 32'hC022);
      chk("ae_count", 32'(cnt[k]), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 16'h0000);
    tick;
    chk("fl_pass_valid", 32'(ov[1]), 32'd0);
    chk("fl_pass_ctrl", 32'(oc[1]), 32'd0);
    chk("fl_pass_data_kept", 32'(od[1]), 32'hC022);
    chk("fl_skid_data_zero", 32'(od[0]), 32'd0);
    // random valid/ready/flush against a depth-limited FIFO model
    sz[0] = 0;
    sz[1] = 0;
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, 8'($urandom), 16'($urandom));
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("rnd_ready", 32'(rdy[k]), 32'(k == 0 ? sz[k] != 2 : (sz[k] == 0 || out_ready_i)));
        if (ov[k]) begin
          chk("rnd_head_ctrl", 32'(oc[k]), 32'(mc[k][0]));
          chk("rnd_head_data", 32'(od[k]), 32'(md[k][0]));
        end
        acc_m[k] = in_valid_i & rdy[k];
        emit_m[k] = ov[k] & out_ready_i;
      end
      tick;
      for (int k = 0; k < 2; k++) begin
        if (flush_i) sz[k] = 0;
        else begin
          if (emit_m[k] && sz[k] > 0) begin
            mc[k][0] = mc[k][1];
            md[k][0] = md[k][1];
            sz[k]--;
          end
          if (acc_m[k] && sz[k] < 2) begin
            mc[k][sz[k]] = in_ctrl_i;
            md[k][sz[k]] = in_data_i;
            sz[k]++;
          end
        end
        chk("rnd_count", 32'(cnt[k]), 32'(sz[k]));
        chk("rnd_valid", 32'(ov[k]), 32'(sz[k] != 0));
        if (!ov[k]) chk("rnd_bubble_ctrl", 32'(oc[k]), 32'd0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
